// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART frame logger: FSM encoding and default frame width.
package uart_dbg_pkg;

  localparam int FRAME_W_DEF = 9;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_FROZEN = 1'b1;

endpackage

// File: rtl/uart_frame_fifo.sv
// Circular frame buffer with head/tail pointers and an occupancy count.
// A same-cycle read and write pops the head and writes the tail.
module uart_frame_fifo
  import uart_dbg_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DEPTH   = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [FRAME_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [FRAME_W-1:0] rd_data,
  output logic [CW-1:0]      count,
  output logic               empty,
  output logic               full
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != FULL_CNT) || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; contents are only visible through
  // rd_data when count is non-zero, so resetting it would only cost area.
  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_frame_logger.sv
// Captures UART frames on the rising edge of frame_valid into a buffer,
// with a match trigger that freezes logging until cleared.
module uart_frame_logger
  import uart_dbg_pkg::*;
#(
  parameter int FRAME_W   = FRAME_W_DEF,
  parameter int DEPTH     = 8,
  parameter int OVERWRITE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FRAME_W-1:0]       frame,
  input  logic                     frame_valid,
  input  logic                     trig_en,
  input  logic [FRAME_W-1:0]       trig_value,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic [FRAME_W-1:0]       debug_frame,
  output logic [FRAME_W-1:0]       rd_frame,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     frozen
);

  logic               frame_valid_q, frame_valid_d;
  logic [0:0]         state_q, state_d;
  logic [FRAME_W-1:0] debug_frame_q, debug_frame_d;
  logic               overflow_q, overflow_d;
  logic               capture, cap_run, pop;
  logic               fifo_wr, fifo_rd;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    frame_valid_d = frame_valid;
    capture       = frame_valid & ~frame_valid_q;
    cap_run       = capture && (state_q == ST_RUN) && !clear;
    pop           = rd_en && !empty && !clear;
    state_d       = state_q;
    debug_frame_d = debug_frame_q;
    overflow_d    = overflow_q;
    fifo_wr       = 1'b0;
    fifo_rd       = pop;
    if (clear) begin
      state_d    = ST_RUN;
      overflow_d = 1'b0;
    end else if (cap_run) begin
      if (full && !pop && (OVERWRITE == 0)) begin
        overflow_d = 1'b1;
      end else begin
        fifo_wr       = 1'b1;
        debug_frame_d = frame;
        // Overwrite on full: popping alongside the write drops the oldest frame.
        if (full && !pop) begin
          fifo_rd    = 1'b1;
          overflow_d = 1'b1;
        end
      end
      if (trig_en && (frame == trig_value)) state_d = ST_FROZEN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_valid_q <= 1'b0;
      state_q       <= ST_RUN;
      debug_frame_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      frame_valid_q <= frame_valid_d;
      state_q       <= state_d;
      debug_frame_q <= debug_frame_d;
      overflow_q    <= overflow_d;
    end
  end

  uart_frame_fifo #(
    .FRAME_W (FRAME_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clear),
    .wr_en   (fifo_wr),
    .wr_data (frame),
    .rd_en   (fifo_rd),
    .rd_data (rd_frame),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  assign debug_frame = debug_frame_q;
  assign overflow    = overflow_q;
  assign frozen      = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_uart_frame_logger.sv
// Directed bench for uart_frame_logger; runs an overwrite and a drop-new instance side by side.
module tb_uart_frame_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] frame = '0;
  logic       frame_valid = 1'b0;
  logic       trig_en = 1'b0;
  logic [8:0] trig_value = '0;
  logic       clear = 1'b0;
  logic       rd_en = 1'b0;

  logic [8:0] ow_debug, ow_rd, nw_debug, nw_rd;
  logic [3:0] ow_count, nw_count;
  logic       ow_empty, ow_full, ow_ovf, ow_frozen;
  logic       nw_empty, nw_full, nw_ovf, nw_frozen;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_frame_logger #(.FRAME_W(9), .DEPTH(8), .OVERWRITE(1)) dut_ow (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .trig_en(trig_en), .trig_value(trig_value), .clear(clear), .rd_en(rd_en),
    .debug_frame(ow_debug), .rd_frame(ow_rd), .count(ow_count), .empty(ow_empty),
    .full(ow_full), .overflow(ow_ovf), .frozen(ow_frozen)
  );

  uart_frame_logger #(.FRAME_W(9), .DEPTH(8), .OVERWRITE(0)) dut_nw (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .trig_en(trig_en), .trig_value(trig_value), .clear(clear), .rd_en(rd_en),
    .debug_frame(nw_debug), .rd_frame(nw_rd), .count(nw_count), .empty(nw_empty),
    .full(nw_full), .overflow(nw_ovf), .frozen(nw_frozen)
  );

  task automatic capture(input logic [8:0] v);
    @(negedge clk); frame = v; frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++; if ({ow_debug, ow_rd, ow_count, ow_empty, ow_full, ow_ovf, ow_frozen} !== {9'd0, 9'd0, 4'd0, 4'b1000}) begin
      n_fail++; $display("FAIL %s_ow: got dbg=%h rd=%h cnt=%0d e=%b f=%b o=%b z=%b, want all zero except empty=1",
        tag, ow_debug, ow_rd, ow_count, ow_empty, ow_full, ow_ovf, ow_frozen); end
    n_cmp++; if ({nw_debug, nw_rd, nw_count, nw_empty, nw_full, nw_ovf, nw_frozen} !== {9'd0, 9'd0, 4'd0, 4'b1000}) begin
      n_fail++; $display("FAIL %s_nw: got dbg=%h rd=%h cnt=%0d e=%b f=%b o=%b z=%b, want all zero except empty=1",
        tag, nw_debug, nw_rd, nw_count, nw_empty, nw_full, nw_ovf, nw_frozen); end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2 check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_edge();
    @(negedge clk); frame = 9'h0AA; frame_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ow_debug !== 9'h0AA) begin n_fail++; $display("FAIL edge_latency: got %h want 0aa", ow_debug); end
    @(negedge clk); frame_valid = 1'b0; frame = 9'h0B3;
    @(negedge clk); frame_valid = 1'b1;
    repeat (3) @(negedge clk);
    frame_valid = 1'b0;
    n_cmp++; if (ow_count !== 4'd2) begin n_fail++; $display("FAIL edge_count: got %0d want 2", ow_count); end
    n_cmp++; if (ow_debug !== 9'h0B3) begin n_fail++; $display("FAIL edge_debug: got %h want 0b3", ow_debug); end
    n_cmp++; if (ow_rd !== 9'h0AA) begin n_fail++; $display("FAIL edge_head: got %h want 0aa", ow_rd); end
  endtask

  task automatic test_fill_overflow();
    do_clear();
    for (int i = 1; i <= 9; i++) capture(9'(i));
    n_cmp++; if (ow_count !== 4'd8 || ow_full !== 1'b1 || ow_ovf !== 1'b1) begin
      n_fail++; $display("FAIL fill_ow_flags: got cnt=%0d full=%b ovf=%b want 8 1 1", ow_count, ow_full, ow_ovf); end
    n_cmp++; if (ow_rd !== 9'd2 || ow_debug !== 9'd9) begin
      n_fail++; $display("FAIL fill_ow_data: got rd=%0d dbg=%0d want 2 9", ow_rd, ow_debug); end
    n_cmp++; if (nw_count !== 4'd8 || nw_full !== 1'b1 || nw_ovf !== 1'b1) begin
      n_fail++; $display("FAIL fill_nw_flags: got cnt=%0d full=%b ovf=%b want 8 1 1", nw_count, nw_full, nw_ovf); end
    n_cmp++; if (nw_rd !== 9'd1 || nw_debug !== 9'd8) begin
      n_fail++; $display("FAIL fill_nw_data: got rd=%0d dbg=%0d want 1 8", nw_rd, nw_debug); end
  endtask

  task automatic test_full_rw();
    logic [8:0] exp;
    do_clear();
    for (int i = 1; i <= 8; i++) capture(9'(i));
    n_cmp++; if (ow_full !== 1'b1 || ow_ovf !== 1'b0 || nw_full !== 1'b1 || nw_ovf !== 1'b0) begin
      n_fail++; $display("FAIL fullrw_pre: got ow f/o=%b%b nw f/o=%b%b want 10 10", ow_full, ow_ovf, nw_full, nw_ovf); end
    @(negedge clk); frame = 9'h01F; frame_valid = 1'b1; rd_en = 1'b1;
    @(negedge clk); frame_valid = 1'b0; rd_en = 1'b0;
    n_cmp++; if (ow_count !== 4'd8 || ow_ovf !== 1'b0 || ow_rd !== 9'd2 || ow_debug !== 9'h01F) begin
      n_fail++; $display("FAIL fullrw_ow: got cnt=%0d ovf=%b rd=%h dbg=%h want 8 0 002 01f", ow_count, ow_ovf, ow_rd, ow_debug); end
    n_cmp++; if (nw_count !== 4'd8 || nw_ovf !== 1'b0 || nw_rd !== 9'd2 || nw_debug !== 9'h01F) begin
      n_fail++; $display("FAIL fullrw_nw: got cnt=%0d ovf=%b rd=%h dbg=%h want 8 0 002 01f", nw_count, nw_ovf, nw_rd, nw_debug); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 9'(i + 2) : 9'h01F;
      n_cmp++; if (ow_rd !== exp || nw_rd !== exp) begin
        n_fail++; $display("FAIL drain_%0d: got ow=%h nw=%h want %h", i, ow_rd, nw_rd, exp); end
      pop_one();
    end
    pop_one();
    n_cmp++; if (ow_count !== 4'd0 || ow_empty !== 1'b1 || ow_ovf !== 1'b0 || ow_rd !== 9'd0) begin
      n_fail++; $display("FAIL empty_read: got cnt=%0d empty=%b ovf=%b rd=%h want 0 1 0 000", ow_count, ow_empty, ow_ovf, ow_rd); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    capture(9'd5);
    capture(9'd6);
    @(negedge clk); frame = 9'd7; frame_valid = 1'b1; rd_en = 1'b1;
    @(negedge clk); frame_valid = 1'b0; rd_en = 1'b0;
    n_cmp++; if (ow_count !== 4'd2 || ow_rd !== 9'd6 || ow_debug !== 9'd7) begin
      n_fail++; $display("FAIL b2b: got cnt=%0d rd=%0d dbg=%0d want 2 6 7", ow_count, ow_rd, ow_debug); end
  endtask

  task automatic test_trigger();
    do_clear();
    trig_en = 1'b1; trig_value = 9'h155;
    capture(9'h011);
    capture(9'h155);
    capture(9'h022);
    n_cmp++; if (ow_frozen !== 1'b1 || ow_count !== 4'd2 || ow_debug !== 9'h155) begin
      n_fail++; $display("FAIL trig_freeze: got frz=%b cnt=%0d dbg=%h want 1 2 155", ow_frozen, ow_count, ow_debug); end
    pop_one();
    n_cmp++; if (ow_frozen !== 1'b1 || ow_count !== 4'd1 || ow_rd !== 9'h155) begin
      n_fail++; $display("FAIL trig_pop: got frz=%b cnt=%0d rd=%h want 1 1 155", ow_frozen, ow_count, ow_rd); end
    do_clear();
    trig_en = 1'b0;
    n_cmp++; if (ow_frozen !== 1'b0 || ow_count !== 4'd0 || ow_debug !== 9'h155) begin
      n_fail++; $display("FAIL trig_clear: got frz=%b cnt=%0d dbg=%h want 0 0 155", ow_frozen, ow_count, ow_debug); end
  endtask

  task automatic test_clear_priority();
    @(negedge clk); frame = 9'h03C; frame_valid = 1'b1; clear = 1'b1;
    @(negedge clk); frame_valid = 1'b0; clear = 1'b0;
    n_cmp++; if (ow_count !== 4'd0 || ow_debug !== 9'h155) begin
      n_fail++; $display("FAIL clear_prio: got cnt=%0d dbg=%h want 0 155", ow_count, ow_debug); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 5; i++) capture(9'(16 + i));
    n_cmp++; if (ow_count !== 4'd5) begin n_fail++; $display("FAIL mid_pre: got %0d want 5", ow_count); end
    @(negedge clk); rst = 1'b0; frame = 9'h077; frame_valid = 1'b1;
    #1 check_reset_values("mid_reset");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    n_cmp++; if (ow_count !== 4'd1 || ow_debug !== 9'h077 || ow_rd !== 9'h077) begin
      n_fail++; $display("FAIL release_capture: got cnt=%0d dbg=%h rd=%h want 1 077 077", ow_count, ow_debug, ow_rd); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_fill_overflow();
    test_full_rw();
    test_back_to_back();
    test_trigger();
    test_clear_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_logger.md
UART_FRAME_LOGGER -- requirements
Module: uart_frame_logger

Interface
REQ-001 Parameter FRAME_W, default 9, SHALL set the width of each received UART frame in bits.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of buffered frames; it SHALL be a power of two, at least 2.
REQ-003 Parameter OVERWRITE, default 1, SHALL select the full-buffer policy: 1 drops the oldest frame, 0 drops the incoming frame.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 frame  input  FRAME_W  SHALL carry the candidate frame, sampled when a capture occurs.
REQ-007 frame_valid  input  1  SHALL mark frame as valid (level); a capture occurs only on its 0->1 transition.
REQ-008 trig_en  input  1  SHALL enable the match trigger.
REQ-009 trig_value  input  FRAME_W  SHALL be the frame value that fires the trigger.
REQ-010 clear  input  1  SHALL empty the buffer, clear flags and return to RUN.
REQ-011 rd_en  input  1  SHALL pop one frame from the buffer head.
REQ-012 debug_frame  output  FRAME_W  SHALL show the most recently captured frame.
REQ-013 rd_frame  output  FRAME_W  SHALL show the oldest buffered frame (head); it is valid when empty=0.
REQ-014 count  output  $clog2(DEPTH)+1  SHALL give the number of buffered frames.
REQ-015 empty / full  output  1 each  SHALL assert when count==0 and count==DEPTH respectively.
REQ-016 overflow  output  1  SHALL be a sticky flag set whenever a frame is dropped.
REQ-017 frozen  output  1  SHALL assert while the FSM is in FROZEN.

Function
REQ-018 frame_valid SHALL be registered once; capture_pulse = frame_valid & ~frame_valid_q. A level held for N cycles SHALL yield exactly one capture.
REQ-019 On a capture in RUN, frame SHALL be written at the tail, and debug_frame SHALL update on the same clock edge (1-cycle latency from the rising edge of frame_valid).
REQ-020 FSM states: RUN, FROZEN. RUN->FROZEN when trig_en=1 and a captured frame equals trig_value; that frame is stored first. FROZEN->RUN only on clear.
REQ-021 In FROZEN, captures SHALL be ignored; debug_frame, buffer contents and count SHALL hold, except that rd_en still pops.
REQ-022 Full and capture with OVERWRITE=1 SHALL write the new frame, advance the head, keep count=DEPTH and set overflow.
REQ-023 Full and capture with OVERWRITE=0 SHALL discard the frame, leave debug_frame unchanged and set overflow.
REQ-024 rd_en with empty=1 SHALL be ignored with no flag change.
REQ-025 Simultaneous capture and rd_en when not full SHALL write and pop, leaving count unchanged.
REQ-026 Simultaneous capture and rd_en when full SHALL pop then write, with no overflow, for both OVERWRITE values.
REQ-027 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 clear SHALL have priority over capture and rd_en in the same cycle; debug_frame SHALL keep its value on clear.

Reset
REQ-029 On rst=0, immediately and asynchronously:
- debug_frame=0, rd_frame=0
- count=0, pointers=0
- empty=1, full=0, overflow=0
- frame_valid_q=0
- FSM=RUN, frozen=0
REQ-030 A capture edge coincident with reset release SHALL NOT be lost; frame_valid_q restarts from 0.

Structure
REQ-031 A shared package uart_dbg_pkg SHALL hold the FSM state encoding (RUN=0, FROZEN=1) and the default FRAME_W=9.
REQ-032 Storage SHALL be a sub-module uart_frame_fifo (parametrised FRAME_W, DEPTH; write/read/clear ports, count output); edge detection, overwrite policy and the FSM stay in the top.

Verification
REQ-033 frame=9'h0AA, frame_valid high for 1 cycle, then frame=9'h0B3, frame_valid high for 3 cycles -> count=2, debug_frame=9'h0B3, rd_frame=9'h0AA.
REQ-034 DEPTH=8, OVERWRITE=1, 9 captures of values 1..9 -> count=8, full=1, overflow=1, rd_frame=2, debug_frame=9.
REQ-035 Same stimulus with OVERWRITE=0 -> count=8, overflow=1, rd_frame=1, debug_frame=8.
REQ-036 trig_en=1, trig_value=9'h155, frames 9'h011, 9'h155, 9'h022 -> frozen=1, count=2, debug_frame=9'h155; clear -> frozen=0, count=0.
REQ-037 Full buffer, capture and rd_en in the same cycle -> count stays 8, overflow stays 0.
REQ-038 rst asserted mid-stream at count=5 -> all outputs reach their reset values before the next clk edge.
